// File: rtl/gemm_job_arbiter.sv
// ============================================================================
//  gemm_job_arbiter
//  Round-robin arbiter admitting one GEMM job at a time to a shared engine,
//  with dimension screening, timeout abort and per-requester completion.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gemm_job_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_ELEMS = 16384,
    parameter int TIMEOUT   = 1048576
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0][15:0]         req_M,
    input  logic [NREQ-1:0][15:0]         req_K,
    input  logic [NREQ-1:0][15:0]         req_N,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [1:0]                    rsp_err,
    output logic                          eng_start,
    output logic [15:0]                   eng_M,
    output logic [15:0]                   eng_K,
    output logic [15:0]                   eng_N,
    input  logic                          eng_done,
    output logic                          eng_rstn,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       cur_id
);

    localparam int          ID_W      = $clog2(NREQ);
    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] MAX_W     = 32'(MAX_ELEMS);
    localparam logic [1:0]  ERR_OK    = 2'b00;
    localparam logic [1:0]  ERR_DIM   = 2'b01;
    localparam logic [1:0]  ERR_TO    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_ABORT = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [15:0]       m_q, m_d, k_q, k_d, n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;
    logic              abort_q, abort_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand_idx;
    int                cand;
    logic [31:0]       prod_mk, prod_kn, prod_mn;
    logic              job_bad;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand     = (int'(last_grant_q) + off) % NREQ;
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        prod_mk = {16'd0, m_q} * {16'd0, k_q};
        prod_kn = {16'd0, k_q} * {16'd0, n_q};
        prod_mn = {16'd0, m_q} * {16'd0, n_q};
        job_bad = (m_q == 16'd0) || (k_q == 16'd0) || (n_q == 16'd0) ||
                  (prod_mk > MAX_W) || (prod_kn > MAX_W) || (prod_mn > MAX_W);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        m_d          = m_q;
        k_d          = k_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        abort_d      = abort_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    cur_id_d = grant_idx;
                    m_d      = req_M[grant_idx];
                    k_d      = req_K[grant_idx];
                    n_d      = req_N[grant_idx];
                    err_d    = ERR_OK;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (job_bad) begin
                    err_d   = ERR_DIM;
                    state_d = S_RESP;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the threshold cycle still counts as success.
                if (eng_done) begin
                    err_d   = ERR_OK;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TO;
                    abort_d = 1'b0;
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ABORT: begin
                if (abort_q) begin
                    state_d = S_RESP;
                end else begin
                    abort_d = 1'b1;
                end
            end
            S_RESP: begin
                last_grant_d = cur_id_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            cur_id_q     <= '0;
            m_q          <= '0;
            k_q          <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            err_q        <= ERR_OK;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            m_q          <= m_d;
            k_q          <= k_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
        end
    end

    // Ready is gated by rstn so a held request is never acknowledged in reset.
    for (genvar i = 0; i < NREQ; i++) begin : g_strobes
        assign req_ready[i] = rstn && (state_q == S_IDLE) && grant_found &&
                              (grant_idx == ID_W'(i));
        assign rsp_valid[i] = (state_q == S_RESP) && (cur_id_q == ID_W'(i));
    end

    assign rsp_err   = err_q;
    assign eng_start = (state_q == S_START);
    assign eng_M     = m_q;
    assign eng_K     = k_q;
    assign eng_N     = n_q;
    assign eng_rstn  = rstn && (state_q != S_ABORT);
    assign busy      = (state_q != S_IDLE);
    assign cur_id    = cur_id_q;

endmodule

`default_nettype wire

// File: tb/tb_gemm_job_arbiter.sv
// ============================================================================
//  tb_gemm_job_arbiter
//  Directed plus randomized job traffic checked against a transaction model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gemm_job_arbiter;

    localparam int NREQ = 4;
    localparam int MAXE = 16384;
    localparam int TO   = 64;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][15:0]  req_M, req_K, req_N;
    logic [NREQ-1:0]        rsp_valid;
    logic [1:0]             rsp_err;
    logic                   eng_start;
    logic [15:0]            eng_M, eng_K, eng_N;
    logic                   eng_done;
    logic                   eng_rstn;
    logic                   busy;
    logic [1:0]             cur_id;

    always #5 clk = ~clk;

    gemm_job_arbiter #(.NREQ(NREQ), .MAX_ELEMS(MAXE), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_M(req_M), .req_K(req_K), .req_N(req_N),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_M(eng_M), .eng_K(eng_K), .eng_N(eng_N),
        .eng_done(eng_done), .eng_rstn(eng_rstn),
        .busy(busy), .cur_id(cur_id)
    );

    int              checks = 0;
    int              errors = 0;
    int              model_last;
    logic [NREQ-1:0] vreq;
    logic [NREQ-1:0] s_rdy, s_rv;
    logic [1:0]      s_err, s_cid;
    logic            s_est, s_erst, s_busy;
    logic [15:0]     s_em, s_ek, s_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int o = 1; o <= NREQ; o++)
            if (v[(last + o) % NREQ]) return (last + o) % NREQ;
        return -1;
    endfunction

    function automatic bit is_bad(input longint m, input longint k, input longint n);
        return (m == 0) || (k == 0) || (n == 0) ||
               (m * k > MAXE) || (k * n > MAXE) || (m * n > MAXE);
    endfunction

    // One clock cycle: drive inputs just after the edge, sample mid-cycle.
    task automatic step(input logic rn, input logic done);
        @(posedge clk);
        #1;
        rstn      = rn;
        req_valid = vreq;
        eng_done  = done;
        #2;
        s_rdy = req_ready; s_rv = rsp_valid; s_err = rsp_err; s_cid = cur_id;
        s_est = eng_start; s_erst = eng_rstn; s_busy = busy;
        s_em = eng_M; s_ek = eng_K; s_en = eng_N;
        chk("rsp_onehot0", 32'($onehot0(s_rv)), 32'd1);
        chk("ready_onehot0", 32'($onehot0(s_rdy)), 32'd1);
        chk("ready_without_valid", 32'(s_rdy & ~req_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(s_rdy), 32'd0);
        chk("rst_rsp_valid", 32'(s_rv), 32'd0);
        chk("rst_rsp_err", 32'(s_err), 32'd0);
        chk("rst_eng_start", 32'(s_est), 32'd0);
        chk("rst_eng_rstn", 32'(s_erst), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_cur_id", 32'(s_cid), 32'd0);
        chk("rst_eng_dims", {s_em, s_ek}, 32'd0);
        chk("rst_eng_n", 32'(s_en), 32'd0);
    endtask

    // dly: >0 engine done that many cycles after start; <0 never done.
    // rst_at: >0 applies reset that many cycles into WAIT.
    task automatic do_job(input bit keep, input int dly, input int rst_at);
        int          exp_id;
        bit          got, bad;
        logic [15:0] m, k, n;
        got = 0;
        for (int c = 0; c < 16 && !got; c++) begin
            step(1'b1, 1'b0);
            chk("idle_busy", 32'(s_busy), 32'd0);
            if (s_rdy != '0) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $error("FAIL grant_wait: observed no grant expected grant within 16 cycles");
            return;
        end
        exp_id = rr_pick(vreq, model_last);
        chk("grant", 32'(s_rdy), 32'(1 << exp_id));
        m = req_M[exp_id]; k = req_K[exp_id]; n = req_N[exp_id];
        bad = is_bad(longint'(m), longint'(k), longint'(n));
        if (!keep) vreq[exp_id] = 1'b0;

        step(1'b1, 1'b0);
        chk("check_busy", 32'(s_busy), 32'd1);
        chk("check_cur_id", 32'(s_cid), 32'(exp_id));
        chk("check_no_start", 32'(s_est), 32'd0);

        step(1'b1, 1'b0);
        if (bad) begin
            chk("bad_rsp_valid", 32'(s_rv), 32'(1 << exp_id));
            chk("bad_rsp_err", 32'(s_err), 32'd1);
            chk("bad_no_start", 32'(s_est), 32'd0);
            model_last = exp_id;
            return;
        end
        chk("eng_start", 32'(s_est), 32'd1);
        chk("eng_mk", {s_em, s_ek}, {m, k});
        chk("eng_n", 32'(s_en), 32'(n));
        chk("start_no_rsp", 32'(s_rv), 32'd0);

        if (rst_at > 0) begin
            vreq = '0;
            for (int c = 1; c <= rst_at; c++) step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            chk("rst_mid_erst", 32'(s_erst), 32'd0);
            chk("rst_mid_ready", 32'(s_rdy), 32'd0);
            step(1'b0, 1'b0);
            chk_reset_outputs();
            step(1'b1, 1'b1);
            chk("post_rst_erst", 32'(s_erst), 32'd1);
            chk("post_rst_rv", 32'(s_rv), 32'd0);
            chk("post_rst_busy", 32'(s_busy), 32'd0);
            step(1'b1, 1'b0);
            chk("dropped_rv", 32'(s_rv), 32'd0);
            chk("dropped_busy", 32'(s_busy), 32'd0);
            model_last = NREQ - 1;
            return;
        end

        if (dly > 0) begin
            for (int c = 1; c < dly; c++) begin
                step(1'b1, 1'b0);
                chk("wait_no_rsp", 32'(s_rv), 32'd0);
                chk("wait_no_start", 32'(s_est), 32'd0);
            end
            step(1'b1, 1'b1);
            chk("done_cycle_no_rsp", 32'(s_rv), 32'd0);
            step(1'b1, 1'b0);
            chk("ok_rsp_valid", 32'(s_rv), 32'(1 << exp_id));
            chk("ok_rsp_err", 32'(s_err), 32'd0);
            chk("ok_eng_rstn", 32'(s_erst), 32'd1);
        end else begin
            for (int c = 1; c <= TO; c++) begin
                step(1'b1, 1'b0);
                chk("to_wait_erst", 32'(s_erst), 32'd1);
                chk("to_wait_no_rsp", 32'(s_rv), 32'd0);
            end
            step(1'b1, 1'b0);
            chk("abort1_erst", 32'(s_erst), 32'd0);
            step(1'b1, 1'b0);
            chk("abort2_erst", 32'(s_erst), 32'd0);
            chk("abort2_no_rsp", 32'(s_rv), 32'd0);
            step(1'b1, 1'b0);
            chk("to_rsp_valid", 32'(s_rv), 32'(1 << exp_id));
            chk("to_rsp_err", 32'(s_err), 32'd2);
            chk("to_erst_back", 32'(s_erst), 32'd1);
        end
        model_last = exp_id;
    endtask

    task automatic set_dims(input int i, input int m, input int k, input int n);
        req_M[i] = 16'(m); req_K[i] = 16'(k); req_N[i] = 16'(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode, d;
        rstn = 1'b0; eng_done = 1'b0; req_valid = '0;
        req_M = '0; req_K = '0; req_N = '0;
        model_last = NREQ - 1;
        vreq = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_dims(i, 4, 4, 4);

        // Reset with all requesters already valid
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_reset_outputs();

        // Continuous requesters: order 0,1,2,3,0
        for (int j = 0; j < 5; j++) do_job(1'b1, int'($urandom_range(1, 10)), 0);

        // Single requester 2, done 30 cycles after start
        vreq = 4'b0100;
        do_job(1'b0, 30, 0);

        // Bad dimensions on requester 1
        set_dims(1, 0, 4, 4);
        vreq = 4'b0010;
        do_job(1'b0, 5, 0);
        set_dims(1, 200, 100, 1);
        vreq = 4'b0010;
        do_job(1'b0, 5, 0);
        set_dims(1, 128, 128, 1);
        vreq = 4'b0010;
        do_job(1'b0, 3, 0);

        // Stray eng_done while idle
        step(1'b1, 1'b1);
        chk("idle_done_busy", 32'(s_busy), 32'd0);
        step(1'b1, 1'b0);
        chk("idle_done_no_rsp", 32'(s_rv), 32'd0);
        chk("idle_done_busy2", 32'(s_busy), 32'd0);

        // Timeout, then done exactly on the threshold cycle
        set_dims(3, 8, 8, 8);
        vreq = 4'b1000;
        do_job(1'b0, -1, 0);
        vreq = 4'b1000;
        do_job(1'b0, TO, 0);

        // Randomized traffic
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                mode = int'($urandom_range(0, 5));
                case (mode)
                    0: set_dims(i, 0, int'($urandom_range(1, 64)), int'($urandom_range(1, 64)));
                    1: set_dims(i, 128, 128, 1);
                    2: set_dims(i, 1, 128, 129);
                    3: set_dims(i, int'($urandom_range(1, 300)), int'($urandom_range(1, 300)),
                                int'($urandom_range(1, 300)));
                    4: set_dims(i, int'($urandom_range(1, 65535)), 1, int'($urandom_range(0, 3)));
                    default: set_dims(i, int'($urandom_range(1, 64)), int'($urandom_range(1, 64)),
                                      int'($urandom_range(1, 64)));
                endcase
            end
            vreq = 4'($urandom_range(1, 15));
            mode = int'($urandom_range(0, 9));
            d = (mode == 0) ? -1 : (mode == 1) ? TO : int'($urandom_range(1, 20));
            do_job(1'($urandom_range(0, 1)), d, 0);
        end

        // Reset during WAIT drops the job and restores requester 0 priority
        set_dims(2, 4, 4, 4);
        vreq = 4'b0100;
        do_job(1'b0, 30, 5);
        vreq = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_dims(i, 2, 2, 2);
        do_job(1'b0, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gemm_job_arbiter.md
GEMM_JOB_ARBITER -- requirements
Module: gemm_job_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of job requesters (2..8).
REQ-002 Parameter MAX_ELEMS, default 16384: capacity of each operand/result BRAM in 32-bit words.
REQ-003 Parameter TIMEOUT, default 1048576: maximum engine cycles per job before abort.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  NREQ  per-requester job request; held until accepted.
REQ-007 req_ready  out  NREQ  one-hot acceptance strobe.
REQ-008 req_M, req_K, req_N  in  NREQx16 each  per-requester job dimensions: A(MxK)*B(KxN).
REQ-009 rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
REQ-010 rsp_err  out  2  status qualified by rsp_valid: 00 ok, 01 bad dimensions, 10 timeout.
REQ-011 eng_start  out  1  one-cycle start pulse to the GEMM engine.
REQ-012 eng_M, eng_K, eng_N  out  16 each  dimensions driven to the engine.
REQ-013 eng_done  in  1  one-cycle engine completion pulse.
REQ-014 eng_rstn  out  1  engine reset, active-low, for timeout recovery.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 cur_id  out  $clog2(NREQ)  index of the job owner; valid while busy.

Function
REQ-017 FSM states: IDLE, CHECK, START, WAIT, ABORT, RESP.
REQ-018 IDLE: if any req_valid is high, grant exactly one requester i by round-robin, assert req_ready[i] for that cycle, latch req_M/K/N[i] and cur_id=i, then go to CHECK.
REQ-019 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 has first priority after reset.
REQ-020 req_ready is never asserted outside IDLE and is never asserted to a requester whose req_valid is low.
REQ-021 CHECK: a job is bad if any dimension is 0, or M*K, K*N or M*N exceeds MAX_ELEMS; products use 32-bit unsigned arithmetic.
REQ-022 Bad job: set rsp_err=01 and go to RESP; the engine is not started.
REQ-023 Good job: go to START.
REQ-024 START: assert eng_start for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-025 eng_M/K/N hold the latched dimensions from CHECK until the next grant, and are 0 after reset.
REQ-026 WAIT: on eng_done, set rsp_err=00 and go to RESP.
REQ-027 WAIT: otherwise, increment the counter; when the counter reaches TIMEOUT-1 without eng_done, set rsp_err=10 and go to ABORT.
REQ-028 ABORT: drive eng_rstn low for exactly 2 cycles, then go to RESP.
REQ-029 RESP: assert rsp_valid[cur_id] for one cycle with rsp_err stable, record last_grant=cur_id, then go to IDLE.
REQ-030 Total latency of a good job: grant-to-eng_start is 2 cycles; eng_done-to-rsp_valid is 1 cycle.
REQ-031 Bad-job latency: grant-to-rsp_valid is 2 cycles.
REQ-032 Grants are back-to-back: the cycle after RESP is IDLE, where a new grant may occur.
REQ-033 eng_done outside WAIT is ignored and causes no response.
REQ-034 eng_done in the same cycle the timeout threshold is reached is a success (rsp_err=00).
REQ-035 A requester deasserting req_valid before grant is simply skipped, with no error.
REQ-036 Only one job is ever in flight, and at most one rsp_valid bit is high in any cycle.

Reset
REQ-037 rstn low in any state, including mid-WAIT, forces IDLE on the next edge.
REQ-038 Outputs under reset: req_ready=0, rsp_valid=0, rsp_err=00, eng_start=0, eng_rstn=0, busy=0, cur_id=0, eng_M/K/N=0.
REQ-039 Registers under reset: counter=0, last_grant=NREQ-1.
REQ-040 After rstn rises, eng_rstn is 1 from the first non-reset cycle.
REQ-041 A job in flight during reset is dropped, with no rsp_valid.

Verification
REQ-042 Requester 2 only, M=K=N=4; eng_done 30 cycles after eng_start -> req_ready[2] in cycle t, eng_start at t+2 with eng_M/K/N=4, rsp_valid[2] with err 00 one cycle after eng_done.
REQ-043 All 4 requesters held valid continuously from reset -> grant order 0,1,2,3,0; each rsp_valid matches its grant.
REQ-044 Requester 1 submits M=0 -> rsp_valid[1] with err 01 two cycles after grant; no eng_start seen. Repeat with M=200, K=100 (20000 > 16384) -> err 01.
REQ-045 TIMEOUT=64, engine never signals done -> rsp_err=10 in the response, eng_rstn low for exactly 2 cycles, rsp_valid 3 cycles after timeout detection.
REQ-046 rstn pulsed low during WAIT, then eng_done arrives -> no rsp_valid, busy=0, next grant goes to requester 0 first.
REQ-047 eng_done pulsed while IDLE -> no rsp_valid, state remains IDLE.
